// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scan
//  Purpose  : Time-multiplexed scan driver for a 4-digit 7-segment display.
//             Each digit is shown for PRESC clock cycles; a full frame is
//             4*PRESC cycles. New data is applied only at frame boundaries
//             so that no frame ever shows a mix of old and new digits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PRESC      : clock cycles each digit is shown (2 .. 2^20)
//  Ports
//    clk        : in  1   clock, rising edge
//    rst        : in  1   synchronous active-high reset
//    data       : in  16  four hex digits, data[3:0] is digit 0 (rightmost)
//    load       : in  1   single-cycle strobe, data sampled on same edge
//    nibble     : out 4   hex value of the digit currently scanned
//    an         : out 4   active-low digit enables, an[i] drives digit i
//    frame_done : out 1   one-cycle pulse at the start of each frame
//  Build option
//    DISP_SCAN_BLANK_EN : when defined, digits above the most significant
//                         nonzero digit are switched off (digit 0 never is)
// ============================================================================
module disp_scan #(
  parameter int PRESC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        load,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int                 c_CNT_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_d;
  logic [15:0]        r_disp;
  logic [15:0]        r_pend_data;
  logic               r_pend;
  logic               r_frame_done;

  logic               w_tick;
  logic               w_wrap;
  logic [3:0]         w_an_scan;

  assign w_tick = (r_cnt == c_CNT_LAST);
  assign w_wrap = w_tick && (r_d == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_d          <= 2'd0;
      r_disp       <= 16'h0000;
      r_pend_data  <= 16'h0000;
      r_pend       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_d   <= r_d + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end

      // The cycle after a wrap is exactly d==0, cnt==0.
      r_frame_done <= w_wrap;

      if (w_wrap) begin
        // A load coinciding with the wrap is newer than anything pending.
        if (load) begin
          r_disp <= data;
        end else if (r_pend) begin
          r_disp <= r_pend_data;
        end
        r_pend <= 1'b0;
      end else if (load) begin
        r_pend_data <= data;
        r_pend      <= 1'b1;
      end
    end
  end

  // Pure decode of registered state: no added latency.
  always_comb begin
    nibble    = r_disp[3:0];
    w_an_scan = 4'b1110;
    case (r_d)
      2'd0: begin nibble = r_disp[3:0];   w_an_scan = 4'b1110; end
      2'd1: begin nibble = r_disp[7:4];   w_an_scan = 4'b1101; end
      2'd2: begin nibble = r_disp[11:8];  w_an_scan = 4'b1011; end
      default: begin nibble = r_disp[15:12]; w_an_scan = 4'b0111; end
    endcase
  end

`ifdef DISP_SCAN_BLANK_EN
  logic [1:0] w_msd;
  logic [3:0] w_blank;

  // Index of the most significant nonzero digit; 0 when disp is all zero,
  // which keeps digit 0 lit for a blank value.
  always_comb begin
    w_msd = 2'd0;
    if (r_disp[15:12] != 4'h0) begin
      w_msd = 2'd3;
    end else if (r_disp[11:8] != 4'h0) begin
      w_msd = 2'd2;
    end else if (r_disp[7:4] != 4'h0) begin
      w_msd = 2'd1;
    end
  end

  always_comb begin
    w_blank    = 4'b0000;
    w_blank[1] = (w_msd < 2'd1);
    w_blank[2] = (w_msd < 2'd2);
    w_blank[3] = (w_msd < 2'd3);
  end

  assign an = w_an_scan | w_blank;
`else
  assign an = w_an_scan;
`endif

  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_scan
//  Purpose  : Directed self-checking bench for disp_scan with PRESC=4
//             (16-cycle frame). Blanking expectations follow the
//             DISP_SCAN_BLANK_EN build option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks;
  int n_pass;
  int k;            // cycles since the last reset edge

  disp_scan #(.PRESC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .load       (load),
    .nibble     (nibble),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_an [4];
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // A load together with reset must be discarded.
    data = 16'hFFFF;
    load = 1'b1;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    k    = 0;
    n_checks++;
    if (an !== 4'b1110 || nibble !== 4'h0 || frame_done !== 1'b0)
      $display("FAIL reset_state: an=%b nibble=%h fd=%b, need an=1110 nibble=0 fd=0", an, nibble, frame_done);
    else n_pass++;
    for (int i = 0; i < 36; i++) begin
      tick();
      n_checks++;
      if (an !== exp_an[(k / 4) % 4] || nibble !== 4'h0 || frame_done !== (k % 16 == 0))
        $display("FAIL reset_scan k=%0d: an=%b nibble=%h fd=%b, need an=%b nibble=0 fd=%b",
                 k, an, nibble, frame_done, exp_an[(k / 4) % 4], (k % 16 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_deferred_load();
    logic [3:0] exp_n [4];
    logic [3:0] exp_an [4];
    exp_n  = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    run_to(5);                // d==1
    data = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    data = 16'h0000;
    while (k < 16) begin
      n_checks++;
      if (nibble !== 4'h0)
        $display("FAIL deferred_hold k=%0d: nibble=%h, need 0", k, nibble);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (frame_done !== 1'b1)
      $display("FAIL deferred_frame_done: fd=%b, need 1", frame_done);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (nibble !== exp_n[i / 4] || an !== exp_an[i / 4])
        $display("FAIL deferred_show k=%0d: nibble=%h an=%b, need nibble=%h an=%b",
                 k, nibble, an, exp_n[i / 4], exp_an[i / 4]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_last_wins();
    do_reset();
    run_to(2);
    data = 16'hAAAA;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(9);
    data = 16'h5555;
    load = 1'b1;
    tick();
    load = 1'b0;
    data = 16'h0000;
    while (k < 32) begin
      n_checks++;
      if (nibble !== ((k < 16) ? 4'h0 : 4'h5))
        $display("FAIL last_wins k=%0d: nibble=%h, need %h", k, nibble, (k < 16) ? 4'h0 : 4'h5);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_load_at_wrap();
    logic [3:0] exp_n [4];
    exp_n = '{4'hF, 4'hE, 4'hE, 4'hB};
    do_reset();
    // Stale pending value must lose to a load on the wrap cycle.
    run_to(3);
    data = 16'h1111;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(15);               // cnt==3, d==3: the wrap cycle
    data = 16'hBEEF;
    load = 1'b1;
    tick();
    load = 1'b0;
    data = 16'h0000;
    n_checks++;
    if (nibble !== 4'hF || an !== 4'b1110 || frame_done !== 1'b1)
      $display("FAIL wrap_first: nibble=%h an=%b fd=%b, need F 1110 1", nibble, an, frame_done);
    else n_pass++;
    // Second frame has no new data: display must hold.
    while (k < 48) begin
      n_checks++;
      if (nibble !== exp_n[((k - 16) / 4) % 4])
        $display("FAIL wrap_show k=%0d: nibble=%h, need %h", k, nibble, exp_n[((k - 16) / 4) % 4]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    run_to(2);
    data = 16'h9999;
    load = 1'b1;
    tick();
    load = 1'b0;
    data = 16'h0000;
    run_to(8);                // d==2
    do_reset();
    n_checks++;
    if (nibble !== 4'h0 || an !== 4'b1110 || frame_done !== 1'b0)
      $display("FAIL midreset_state: nibble=%h an=%b fd=%b, need 0 1110 0", nibble, an, frame_done);
    else n_pass++;
    while (k < 36) begin
      tick();
      n_checks++;
      if (nibble !== 4'h0)
        $display("FAIL midreset_drop k=%0d: nibble=%h, need 0", k, nibble);
      else n_pass++;
    end
  endtask

  task automatic test_blanking();
    logic [3:0] exp_n  [4];
    logic [3:0] exp_an [4];
    logic [3:0] exp_z  [4];
    exp_n = '{4'h2, 4'h4, 4'h0, 4'h0};
`ifdef DISP_SCAN_BLANK_EN
    exp_an = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_z  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
`else
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_z  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    do_reset();
    run_to(1);
    data = 16'h0042;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_to(16);
    while (k < 32) begin
      n_checks++;
      if (nibble !== exp_n[(k / 4) % 4] || an !== exp_an[(k / 4) % 4])
        $display("FAIL blank_0042 k=%0d: nibble=%h an=%b, need nibble=%h an=%b",
                 k, nibble, an, exp_n[(k / 4) % 4], exp_an[(k / 4) % 4]);
      else n_pass++;
      tick();
    end
    do_reset();
    while (k < 16) begin
      n_checks++;
      if (nibble !== 4'h0 || an !== exp_z[(k / 4) % 4])
        $display("FAIL blank_0000 k=%0d: nibble=%h an=%b, need nibble=0 an=%b",
                 k, nibble, an, exp_z[(k / 4) % 4]);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    k        = 0;
    rst      = 1'b1;
    load     = 1'b0;
    data     = 16'h0000;
    tick();
    tick();
    test_reset();
    test_deferred_load();
    test_last_wins();
    test_load_at_wrap();
    test_reset_mid_frame();
    test_blanking();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
